// File: rtl/ds_pkg.sv
// Shared types and helpers for the streaming image downsampler.
package ds_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ds_state_t;

   localparam logic MODE_DECIM = 1'b0;
   localparam logic MODE_AVG   = 1'b1;

   // Smallest r with 2**r >= value; exact for the power-of-two factors used here.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ds_line_acc.sv
// Per-line partial-sum memory: one entry per horizontal group, combinational read, synchronous write.
module ds_line_acc #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 10,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data
);

   // No reset: the first row of every group overwrites whatever is stored.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/image_downsampler.sv
// Streaming FACTOR x FACTOR downsampler (decimate or box average) for raster-order pixels.
// Build option: define DS_ROUND_EN for round-half-up averaging instead of truncation.
module image_downsampler
   import ds_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int FACTOR = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output ds_state_t        dbg_state
);

   localparam int LOG2F  = log2(FACTOR);
   localparam int SHIFT  = 2 * LOG2F;
   localparam int ACC_W  = PIX_W + SHIFT;
   localparam int GROUPS = IMG_W / FACTOR;
   localparam int GAW    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [ACC_W-1:0] ROUND_ADD = ACC_W'(1) << (SHIFT - 1);

   ds_state_t        r_state, w_state_next;
   logic             r_mode;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [ACC_W-1:0] r_hsum;
   logic             r_out_valid;
   logic [PIX_W-1:0] r_out_data;

   logic             w_accept, w_done, w_emit, w_acc_wr;
   logic             w_col_last, w_row_last;
   logic             w_grp_first_col, w_grp_last_col, w_grp_first_row, w_grp_last_row;
   logic [GAW-1:0]   w_grp;
   logic [ACC_W-1:0] w_pix_ext, w_hsum_base, w_acc_rd, w_acc_base, w_total, w_rounded;
   logic [PIX_W-1:0] w_avg, w_emit_data;

   // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
   // the producer holds valid and data stable until that edge, and ready never waits on valid.
   assign w_accept  = in_valid & in_ready;
   assign in_ready  = (r_state == RUN) & (~r_out_valid | out_ready);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state != IDLE);
   assign done      = w_done;
   assign dbg_state = r_state;

   assign w_col_last      = (r_col == CW'(IMG_W - 1));
   assign w_row_last      = (r_row == RW'(IMG_H - 1));
   assign w_grp_first_col = (r_col[LOG2F-1:0] == '0);
   assign w_grp_last_col  = &r_col[LOG2F-1:0];
   assign w_grp_first_row = (r_row[LOG2F-1:0] == '0);
   assign w_grp_last_row  = &r_row[LOG2F-1:0];
   assign w_grp           = GAW'(r_col >> LOG2F);

   assign w_pix_ext   = {{SHIFT{1'b0}}, in_data};
   assign w_hsum_base = w_grp_first_col ? '0 : r_hsum;
   assign w_acc_base  = w_grp_first_row ? '0 : w_acc_rd;
   assign w_total     = w_acc_base + r_hsum + w_pix_ext;
`ifdef DS_ROUND_EN
   assign w_rounded   = w_total + ROUND_ADD;
`else
   assign w_rounded   = w_total;
`endif
   assign w_avg       = w_rounded[ACC_W-1:SHIFT];

   // Average mode: intermediate group rows fold into the line memory, the last row emits.
   assign w_acc_wr    = w_accept & (r_mode == MODE_AVG) & w_grp_last_col & ~w_grp_last_row;
   assign w_emit      = w_accept & ((r_mode == MODE_DECIM) ? (w_grp_first_col & w_grp_first_row)
                                                           : (w_grp_last_col & w_grp_last_row));
   assign w_emit_data = (r_mode == MODE_DECIM) ? in_data : w_avg;

   ds_line_acc #(
      .DEPTH (GROUPS),
      .WIDTH (ACC_W),
      .AW    (GAW)
   ) u_line_acc (
      .clock     (clock),
      .i_rd_addr (w_grp),
      .o_rd_data (w_acc_rd),
      .i_wr_en   (w_acc_wr),
      .i_wr_addr (w_grp),
      .i_wr_data (w_total)
   );

   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      case (r_state)
         IDLE:  if (start) w_state_next = RUN;
         RUN:   if (w_accept & w_col_last & w_row_last) w_state_next = DRAIN;
         DRAIN: begin
            if (~r_out_valid | out_ready) begin
               w_state_next = IDLE;
               w_done       = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_mode  <= MODE_DECIM;
      end else begin
         r_state <= w_state_next;
         if ((r_state == IDLE) && start) r_mode <= mode;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_hsum <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         r_hsum <= w_hsum_base + w_pix_ext;
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Single-entry output stage; a new emit can only coincide with the old beat being taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_emit_data;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_image_downsampler.sv
// Scoreboard bench for image_downsampler on an 8x4 image with FACTOR 2.
module tb_image_downsampler;
   import ds_pkg::*;

   localparam int PIX_W  = 8;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 4;
   localparam int FACTOR = 2;
   localparam int NPIX   = IMG_W * IMG_H;

   logic             clock     = 1'b0;
   logic             reset_n   = 1'b1;
   logic             start     = 1'b0;
   logic             mode      = 1'b0;
   logic             in_valid  = 1'b0;
   logic [PIX_W-1:0] in_data   = '0;
   logic             out_ready = 1'b1;
   logic             in_ready, out_valid, busy, done;
   logic [PIX_W-1:0] out_data;
   ds_state_t        dbg_state;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [PIX_W-1:0] exp_q[$];
   logic [PIX_W-1:0] frame [IMG_H][IMG_W];

   always #5 clock = ~clock;

   image_downsampler #(
      .PIX_W (PIX_W), .IMG_W (IMG_W), .IMG_H (IMG_H), .FACTOR (FACTOR)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // Output beats are taken on the next rising edge; compare them here, half a cycle before.
   always @(negedge clock) begin
      logic [PIX_W-1:0] exp_v;
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected: got %0d, required no output", out_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (out_data !== exp_v) begin
               failures++;
               $display("FAIL out_data: got %0d, required %0d", out_data, exp_v);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic fill_frame(input int kind);
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            case (kind)
               0:       frame[r][c] = PIX_W'(c + 8 * r);
               1:       frame[r][c] = '1;
               default: frame[r][c] = PIX_W'($urandom_range(0, 255));
            endcase
         end
      end
   endtask

   task automatic push_expected(input logic m);
      int sum;
      for (int br = 0; br < IMG_H / FACTOR; br++) begin
         for (int bc = 0; bc < IMG_W / FACTOR; bc++) begin
            if (m == MODE_DECIM) begin
               exp_q.push_back(frame[br*FACTOR][bc*FACTOR]);
            end else begin
               sum = 0;
               for (int dr = 0; dr < FACTOR; dr++)
                  for (int dc = 0; dc < FACTOR; dc++)
                     sum += int'(frame[br*FACTOR+dr][bc*FACTOR+dc]);
`ifdef DS_ROUND_EN
               sum += (FACTOR * FACTOR) / 2;
`endif
               exp_q.push_back(PIX_W'(sum / (FACTOR * FACTOR)));
            end
         end
      end
   endtask

   task automatic pulse_start(input logic m);
      start = 1'b1;
      mode  = m;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic send_pixel(input logic [PIX_W-1:0] d);
      int  t;
      bit  ok;
      t  = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && t < 200) begin
         @(negedge clock);
         if (in_ready === 1'b1) ok = 1'b1;
         else t++;
      end
      if (ok) begin
         @(posedge clock); #1;
      end else begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout: got no accept in %0d cycles, required accept", t);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_range(input int first, input int n);
      for (int i = first; i < first + n; i++) send_pixel(frame[i / IMG_W][i % IMG_W]);
   endtask

   task automatic wait_idle;
      int t;
      t = 0;
      @(negedge clock);
      while (busy !== 1'b0 && t < 300) begin
         @(negedge clock);
         t++;
      end
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: got busy=%b after %0d cycles, required 0", busy, t);
      end
      @(negedge clock);
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
      checks++; if (done !== 1'b0)      begin failures++; $display("FAIL rst_done: got %b, required 0", done); end
      checks++; if (out_data !== '0)    begin failures++; $display("FAIL rst_out_data: got %0d, required 0", out_data); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, IDLE); end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_frame(input int kind, input logic m, input string name);
      int d0;
      fill_frame(kind);
      push_expected(m);
      d0 = done_cnt;
      pulse_start(m);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_start: got %b, required 1", name, busy); end
      send_range(0, NPIX);
      wait_idle();
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done: got %0d pulses, required 1", name, done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end: got %b, required 0", name, busy); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL %s_count: got %0d missing outputs, required 0", name, exp_q.size()); end
   endtask

   task automatic test_backpressure;
      logic [PIX_W-1:0] held;
      int t;
      fill_frame(0);
      push_expected(MODE_AVG);
      pulse_start(MODE_AVG);
      fork
         send_range(0, NPIX);
         begin
            t = 0;
            while (out_valid !== 1'b1 && t < 100) begin
               @(posedge clock); #1;
               t++;
            end
            checks++;
            if (out_valid !== 1'b1) begin
               failures++;
               $display("FAIL bp_wait_valid: got out_valid=%b, required 1", out_valid);
            end else begin
               out_ready = 1'b0;
               held = out_data;
               repeat (10) begin
                  @(negedge clock);
                  checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
                  checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
                  checks++; if (out_data !== held)  begin failures++; $display("FAIL bp_out_data: got %0d, required %0d", out_data, held); end
               end
               @(posedge clock); #1;
               out_ready = 1'b1;
            end
         end
      join
      wait_idle();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_count: got %0d missing outputs, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_midframe;
      fill_frame(0);
      push_expected(MODE_AVG);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      pulse_start(MODE_AVG);
      send_range(0, 13);
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_partial: got %0d missing outputs, required 0", exp_q.size()); end
      reset_n = 1'b0;
      @(negedge clock);
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_busy: got %b, required 0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b, required 0", out_valid); end
      exp_q.delete();
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      test_frame(2, MODE_AVG, "mid_restart");
   endtask

   task automatic test_start_ignored;
      fill_frame(0);
      push_expected(MODE_DECIM);
      pulse_start(MODE_DECIM);
      send_range(0, 5);
      start = 1'b1;
      mode  = MODE_AVG;
      @(posedge clock); #1;
      start = 1'b0;
      mode  = MODE_DECIM;
      checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL ign_state: got %0d, required %0d", dbg_state, RUN); end
      send_range(5, NPIX - 5);
      wait_idle();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ign_count: got %0d missing outputs, required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back;
      for (int f = 0; f < 2; f++) begin
         fill_frame(2);
         push_expected(f[0] ? MODE_DECIM : MODE_AVG);
         pulse_start(f[0] ? MODE_DECIM : MODE_AVG);
         fork
            send_range(0, NPIX);
            begin
               repeat (50) begin
                  @(posedge clock); #1;
                  out_ready = ($urandom_range(0, 1) == 1);
               end
               out_ready = 1'b1;
            end
         join
         wait_idle();
         checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_count: got %0d missing outputs, required 0", exp_q.size()); end
      end
   endtask

   initial begin
      test_reset();
      test_frame(0, MODE_DECIM, "decim");
      test_frame(0, MODE_AVG, "avg");
      test_frame(1, MODE_AVG, "avg_max");
      test_frame(2, MODE_AVG, "avg_rand");
      test_backpressure();
      test_reset_midframe();
      test_start_ignored();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
